// File: rtl/judge_tally.sv
// rtl/judge_tally.sv - judge code classifier with per-class tallies, tagged FIFO and run FSM
// Optional feature macro: JUDGE_TALLY_SAT_EN (tallies saturate instead of wrapping).
module judge_tally #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       judge,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_judge,
  output logic [CNT_W-1:0] out_seq,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             busy,
  output logic             done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e           state_q, state_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] seq_q, seq_d;
  logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d, err_q, err_d;
  logic             done_q, done_d;
  logic [2:0]       mem_judge_q [DEPTH];
  logic [CNT_W-1:0] mem_seq_q   [DEPTH];

  logic full, empty, accept, push, pop;

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
`ifdef JUDGE_TALLY_SAT_EN
    return (&v) ? v : v + CNT_ONE;
`else
    return v + CNT_ONE;
`endif
  endfunction

  assign full      = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign in_ready  = (state_q == S_RUN) && !full;
  assign out_valid = !empty;
  assign accept    = in_valid && in_ready;
  assign push      = accept && (judge != 3'b000);
  assign pop       = out_valid && out_ready;

  assign out_judge = out_valid ? mem_judge_q[rd_ptr_q[AW-1:0]] : 3'b000;
  assign out_seq   = out_valid ? mem_seq_q[rd_ptr_q[AW-1:0]] : '0;
  assign pass_cnt  = pass_q;
  assign fail_cnt  = fail_q;
  assign err_cnt   = err_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    seq_d    = seq_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    err_d    = err_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          seq_d   = '0;
          pass_d  = '0;
          fail_d  = '0;
          err_d   = '0;
        end
      end
      S_RUN: begin
        if (stop) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Leave on the edge that empties the FIFO so done lines up with the last pop.
        if (rd_ptr_d == wr_ptr_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push) begin
      seq_d = seq_q + CNT_ONE;
      case (judge)
        3'b001:  pass_d = bump(pass_q);
        3'b010:  fail_d = bump(fail_q);
        default: err_d  = bump(err_q);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      seq_q    <= '0;
      pass_q   <= '0;
      fail_q   <= '0;
      err_q    <= '0;
      done_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_judge_q[i] <= 3'b000;
        mem_seq_q[i]   <= '0;
      end
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      seq_q    <= seq_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      err_q    <= err_d;
      done_q   <= done_d;
      if (push) begin
        mem_judge_q[wr_ptr_q[AW-1:0]] <= judge;
        mem_seq_q[wr_ptr_q[AW-1:0]]   <= seq_q;
      end
    end
  end

endmodule

// File: tb/tb_judge_tally.sv
// tb/tb_judge_tally.sv - directed self-checking bench for judge_tally
// Honours JUDGE_TALLY_SAT_EN for the overflow expectation.
module tb_judge_tally;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [2:0]       judge = 3'b000;
  logic             in_ready, out_valid, busy, done;
  logic [2:0]       out_judge;
  logic [CNT_W-1:0] out_seq, pass_cnt, fail_cnt, err_cnt;

  int total = 0;
  int bad = 0;
  int done_seen = 0;
  logic [2:0]       q_judge [$];
  logic [CNT_W-1:0] q_seq   [$];

  judge_tally #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .in_valid(in_valid), .in_ready(in_ready), .judge(judge),
    .out_valid(out_valid), .out_ready(out_ready), .out_judge(out_judge), .out_seq(out_seq),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err_cnt(err_cnt),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: log any pop and done seen in the current cycle, then advance.
  task automatic step();
    if (out_valid && out_ready) begin
      q_judge.push_back(out_judge);
      q_seq.push_back(out_seq);
    end
    if (done) done_seen++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic stop_and_wait(input string tag);
    int n;
    n = 0;
    done_seen = 0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    while (done_seen == 0 && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_done"}, done_seen, 1);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    logic [2:0] codes [4];
    codes = '{3'b001, 3'b010, 3'b111, 3'b000};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_judge", out_judge, 3'b000);
    chk("rst_out_seq", out_seq, 0);
    chk("rst_tallies", {pass_cnt, fail_cnt, err_cnt}, 0);
    chk("rst_busy_done", {busy, done}, 2'b00);
    rst_n = 1'b1;
    step();

    // Basic run
    out_ready = 1'b1;
    do_start();
    chk("basic_busy", busy, 1'b1);
    chk("basic_in_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      judge = codes[i];
      step();
    end
    in_valid = 1'b0;
    stop_and_wait("basic");
    chk("basic_tallies", {pass_cnt, fail_cnt, err_cnt}, {4'd1, 4'd1, 4'd1});
    chk("basic_npop", q_judge.size(), 3);
    if (q_judge.size() == 3) begin
      chk("basic_e0", {q_judge[0], q_seq[0]}, {3'b001, 4'd0});
      chk("basic_e1", {q_judge[1], q_seq[1]}, {3'b010, 4'd1});
      chk("basic_e2", {q_judge[2], q_seq[2]}, {3'b111, 4'd2});
    end
    step();
    chk("basic_done_once", done_seen, 1);

    // Fill and backpressure
    out_ready = 1'b0;
    do_start();
    in_valid = 1'b1;
    judge = 3'b001;
    for (int i = 0; i < 4; i++) begin
      chk("fill_ready", in_ready, 1'b1);
      step();
    end
    chk("fill_full_ready", in_ready, 1'b0);
    step();
    step();
    chk("fill_held_ready", in_ready, 1'b0);
    chk("fill_held_cnt", pass_cnt, 4);
    out_ready = 1'b1;
    chk("fill_pop_cycle_ready", in_ready, 1'b0);
    step();
    out_ready = 1'b0;
    chk("fill_after_pop_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    chk("fill_5th_cnt", pass_cnt, 5);
    chk("fill_refull_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    stop_and_wait("fill");

    // Drain
    out_ready = 1'b0;
    do_start();
    in_valid = 1'b1;
    judge = 3'b010;
    repeat (3) step();
    in_valid = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("drain_busy", busy, 1'b1);
      chk("drain_in_ready", in_ready, 1'b0);
      step();
    end
    out_ready = 1'b1;
    repeat (3) step();
    chk("drain_empty", out_valid, 1'b0);
    chk("drain_done", done, 1'b1);
    chk("drain_idle", busy, 1'b0);
    step();
    chk("drain_done_pulse", done, 1'b0);

    // Overflow with CNT_W=4
    q_judge.delete();
    q_seq.delete();
    do_start();
    in_valid = 1'b1;
    judge = 3'b010;
    repeat (17) step();
    in_valid = 1'b0;
    step();
    step();
`ifdef JUDGE_TALLY_SAT_EN
    chk("ovf_fail_cnt", fail_cnt, 15);
`else
    chk("ovf_fail_cnt", fail_cnt, 1);
`endif
    chk("ovf_npop", q_seq.size(), 17);
    if (q_seq.size() == 17) begin
      chk("ovf_seq15", q_seq[15], 15);
      chk("ovf_seq_last", q_seq[16], 0);
    end
    stop_and_wait("ovf");

    // Reset mid-run
    out_ready = 1'b0;
    do_start();
    in_valid = 1'b1;
    judge = 3'b001;
    repeat (2) step();
    in_valid = 1'b0;
    chk("mid_pre_valid", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_flags", {in_ready, out_valid, busy, done}, 4'b0000);
    chk("mid_rst_head", {out_judge, out_seq}, 7'd0);
    chk("mid_rst_tallies", {pass_cnt, fail_cnt, err_cnt}, 0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_start();
    in_valid = 1'b1;
    judge = 3'b001;
    step();
    in_valid = 1'b0;
    chk("mid_head", {out_valid, out_judge, out_seq}, {1'b1, 3'b001, 4'd0});
    chk("mid_pass", pass_cnt, 1);

    // Ignored controls
    do_start();
    chk("ign_start_run_cnt", pass_cnt, 1);
    chk("ign_start_run_state", {busy, in_ready, out_valid}, 3'b111);
    out_ready = 1'b1;
    stop_and_wait("ign1");
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("ign_stop_idle", {busy, in_ready}, 2'b00);
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    chk("ign_both_idle", {busy, in_ready}, 2'b11);
    stop_and_wait("ign2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
